axi_rw_arbiter: RTL and testbench

AXI_RW_ARBITER -- requirements
Module: axi_rw_arbiter

---
 rtl/axi_rw_arbiter_pkg.sv | 18 +
 rtl/axi_rw_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_axi_rw_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_rw_arbiter_pkg.sv
// Shared definitions for the AXI read/write arbiter.
// Holds the FSM state encoding and the default burst-parameter widths used by both AXI masters.
package axi_rw_arbiter_pkg;

    localparam int DEF_ADDR_W = 30;
    localparam int DEF_LEN_W  = 8;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WR_ISSUE = 3'd1;
    localparam logic [2:0] ST_WR_BUSY  = 3'd2;
    localparam logic [2:0] ST_RD_ISSUE = 3'd3;
    localparam logic [2:0] ST_RD_BUSY  = 3'd4;

    function automatic logic is_wr_state(input logic [2:0] st);
        return (st == ST_WR_ISSUE) || (st == ST_WR_BUSY);
    endfunction

endpackage

// File: rtl/axi_rw_arbiter.sv
// Arbitrates burst requests from the write and read user sides onto the two AXI masters,
// alternating on contention. Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module axi_rw_arbiter
    import axi_rw_arbiter_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int LEN_W       = DEF_LEN_W,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [LEN_W-1:0]  wr_req_len,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_req_addr,
    input  logic [LEN_W-1:0]  rd_req_len,
    output logic              wr_ack,
    output logic              rd_ack,
    output logic              wr_start,
    output logic              rd_start,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [LEN_W-1:0]  wr_len,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [LEN_W-1:0]  rd_len,
    input  logic              wr_ready,
    input  logic              rd_ready,
    input  logic              wr_done,
    input  logic              rd_done,
    output logic              busy,
    output logic              grant_wr
`ifdef ARB_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    logic [2:0]        state_q, state_d;
    logic              last_wr_q, last_wr_d;
    logic              wr_ack_q, wr_ack_d;
    logic              rd_ack_q, rd_ack_d;
    logic              wr_start_q, wr_start_d;
    logic              rd_start_q, rd_start_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [LEN_W-1:0]  wr_len_q, wr_len_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [LEN_W-1:0]  rd_len_q, rd_len_d;
    logic              wr_elig, rd_elig, pick_wr;

    assign wr_elig = wr_req & wr_ready;
    assign rd_elig = rd_req & rd_ready;
    // On contention the direction not served last wins.
    assign pick_wr = wr_elig & (~rd_elig | ~last_wr_q);

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             timeout_err_q, timeout_err_d;
    logic             wd_expired;

    assign wd_expired = (wd_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
    // TIMEOUT_CYC is only meaningful with the watchdog; referenced here so the port list stays stable.
    if (TIMEOUT_CYC < 1) begin : g_timeout_unused
    end
`endif

    always_comb begin
        state_d    = state_q;
        last_wr_d  = last_wr_q;
        wr_ack_d   = 1'b0;
        rd_ack_d   = 1'b0;
        wr_start_d = 1'b0;
        rd_start_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_len_d   = wr_len_q;
        rd_addr_d  = rd_addr_q;
        rd_len_d   = rd_len_q;
`ifdef ARB_TIMEOUT_EN
        timeout_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_wr) begin
                    state_d   = ST_WR_ISSUE;
                    wr_ack_d  = 1'b1;
                    wr_addr_d = wr_req_addr;
                    wr_len_d  = wr_req_len;
                end else if (rd_elig) begin
                    state_d   = ST_RD_ISSUE;
                    rd_ack_d  = 1'b1;
                    rd_addr_d = rd_req_addr;
                    rd_len_d  = rd_req_len;
                end
            end
            ST_WR_ISSUE: begin
                wr_start_d = 1'b1;
                state_d    = ST_WR_BUSY;
            end
            ST_RD_ISSUE: begin
                rd_start_d = 1'b1;
                state_d    = ST_RD_BUSY;
            end
            ST_WR_BUSY: begin
                if (wr_done) begin
                    state_d   = ST_IDLE;
                    last_wr_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                end else if (wd_expired) begin
                    // An abandoned burst still counts as served for fairness.
                    state_d       = ST_IDLE;
                    last_wr_d     = 1'b1;
                    timeout_err_d = 1'b1;
`endif
                end
            end
            ST_RD_BUSY: begin
                if (rd_done) begin
                    state_d   = ST_IDLE;
                    last_wr_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
                end else if (wd_expired) begin
                    state_d       = ST_IDLE;
                    last_wr_d     = 1'b0;
                    timeout_err_d = 1'b1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    always_comb begin
        wd_cnt_d = '0;
        if ((state_d == state_q) && ((state_q == ST_WR_BUSY) || (state_q == ST_RD_BUSY))) begin
            wd_cnt_d = wd_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            last_wr_q  <= 1'b0;
            wr_ack_q   <= 1'b0;
            rd_ack_q   <= 1'b0;
            wr_start_q <= 1'b0;
            rd_start_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_len_q   <= '0;
            rd_addr_q  <= '0;
            rd_len_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_wr_q  <= last_wr_d;
            wr_ack_q   <= wr_ack_d;
            rd_ack_q   <= rd_ack_d;
            wr_start_q <= wr_start_d;
            rd_start_q <= rd_start_d;
            wr_addr_q  <= wr_addr_d;
            wr_len_q   <= wr_len_d;
            rd_addr_q  <= rd_addr_d;
            rd_len_q   <= rd_len_d;
        end
    end

    assign wr_ack   = wr_ack_q;
    assign rd_ack   = rd_ack_q;
    assign wr_start = wr_start_q;
    assign rd_start = rd_start_q;
    assign wr_addr  = wr_addr_q;
    assign wr_len   = wr_len_q;
    assign rd_addr  = rd_addr_q;
    assign rd_len   = rd_len_q;
    assign busy     = (state_q != ST_IDLE);
    assign grant_wr = is_wr_state(state_q);

endmodule

// File: tb/tb_axi_rw_arbiter.sv
// Self-checking bench for axi_rw_arbiter: contest table, directed corner cases and
// randomized traffic against a transaction-level owner/age model.
module tb_axi_rw_arbiter;

    localparam int AW = 30;
    localparam int LW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_req = 1'b0, rd_req = 1'b0;
    logic [AW-1:0] wr_req_addr = '0, rd_req_addr = '0;
    logic [LW-1:0] wr_req_len = '0, rd_req_len = '0;
    logic          wr_ack, rd_ack, wr_start, rd_start;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [LW-1:0] wr_len, rd_len;
    logic          wr_ready = 1'b0, rd_ready = 1'b0, wr_done = 1'b0, rd_done = 1'b0;
    logic          busy, grant_wr;
`ifdef ARB_TIMEOUT_EN
    logic          timeout_err;
`endif

    int checks = 0;
    int errors = 0;

    axi_rw_arbiter #(.ADDR_W(AW), .LEN_W(LW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_req(wr_req), .wr_req_addr(wr_req_addr), .wr_req_len(wr_req_len),
        .rd_req(rd_req), .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
        .wr_ack(wr_ack), .rd_ack(rd_ack), .wr_start(wr_start), .rd_start(rd_start),
        .wr_addr(wr_addr), .wr_len(wr_len), .rd_addr(rd_addr), .rd_len(rd_len),
        .wr_ready(wr_ready), .rd_ready(rd_ready), .wr_done(wr_done), .rd_done(rd_done),
        .busy(busy), .grant_wr(grant_wr)
`ifdef ARB_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic wr_req, rd_req, wr_ready, rd_ready, exp_wr_ack, exp_rd_ack;
    } vec_t;
    vec_t vecs[13];

    // Model: who owns the bus and how many edges since its ack.
    int            m_owner;   // 0 none, 1 write, 2 read
    int            m_age;
    bit            m_last_wr;
    bit            m_to;
    logic [AW-1:0] m_wr_addr, m_rd_addr;
    logic [LW-1:0] m_wr_len, m_rd_len;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] dut_vec();
        return 128'({wr_ack, rd_ack, wr_start, rd_start, busy, grant_wr, wr_addr, wr_len, rd_addr, rd_len});
    endfunction

    function automatic logic [127:0] model_vec();
        logic w_ack, r_ack, w_st, r_st, bsy, gw;
        w_ack = (m_owner == 1) && (m_age == 0);
        r_ack = (m_owner == 2) && (m_age == 0);
        w_st  = (m_owner == 1) && (m_age == 1);
        r_st  = (m_owner == 2) && (m_age == 1);
        bsy   = (m_owner != 0);
        gw    = (m_owner == 1);
        return 128'({w_ack, r_ack, w_st, r_st, bsy, gw, m_wr_addr, m_wr_len, m_rd_addr, m_rd_len});
    endfunction

    task automatic model_reset();
        m_owner = 0; m_age = 0; m_last_wr = 0; m_to = 0;
        m_wr_addr = '0; m_rd_addr = '0; m_wr_len = '0; m_rd_len = '0;
    endtask

    task automatic model_step();
        bit we, re, dn;
        m_to = 0;
        if (m_owner == 0) begin
            we = wr_req & wr_ready;
            re = rd_req & rd_ready;
            if (we && (!re || !m_last_wr)) begin
                m_owner = 1; m_age = 0; m_wr_addr = wr_req_addr; m_wr_len = wr_req_len;
            end else if (re) begin
                m_owner = 2; m_age = 0; m_rd_addr = rd_req_addr; m_rd_len = rd_req_len;
            end
        end else begin
            dn = (m_owner == 1) ? wr_done : rd_done;
            if (m_age >= 1 && dn) begin
                m_last_wr = (m_owner == 1);
                m_owner = 0;
`ifdef ARB_TIMEOUT_EN
            end else if (m_age >= TO) begin
                m_last_wr = (m_owner == 1);
                m_owner = 0;
                m_to = 1;
`endif
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic acc;

        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset state
        #12;
        check("reset_outputs", dut_vec(), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Contest table: each granted burst is completed before the next vector
        for (int i = 0; i < 13; i++) begin
            wr_req = vecs[i].wr_req; rd_req = vecs[i].rd_req;
            wr_ready = vecs[i].wr_ready; rd_ready = vecs[i].rd_ready;
            wr_req_addr = AW'(32'h40 + i); rd_req_addr = AW'(32'h80 + i);
            wr_req_len = LW'(i); rd_req_len = LW'(i + 100);
            tick();
            check($sformatf("vec%0d_ack", i), 128'({wr_ack, rd_ack}),
                  128'({vecs[i].exp_wr_ack, vecs[i].exp_rd_ack}));
            wr_req = 1'b0; rd_req = 1'b0; wr_ready = 1'b1; rd_ready = 1'b1;
            if (vecs[i].exp_wr_ack || vecs[i].exp_rd_ack) begin
                tick();
                if (vecs[i].exp_wr_ack) begin
                    check($sformatf("vec%0d_wr_param", i), 128'({wr_start, wr_addr, wr_len}),
                          128'({1'b1, AW'(32'h40 + i), LW'(i)}));
                    wr_done = 1'b1;
                end else begin
                    check($sformatf("vec%0d_rd_param", i), 128'({rd_start, rd_addr, rd_len}),
                          128'({1'b1, AW'(32'h80 + i), LW'(i + 100)}));
                    rd_done = 1'b1;
                end
                tick();
                wr_done = 1'b0; rd_done = 1'b0;
                check($sformatf("vec%0d_idle", i), 128'(busy), 128'd0);
            end
            $display("vec %0d: req w%0d r%0d rdy w%0d r%0d -> ack w%0d r%0d", i,
                     vecs[i].wr_req, vecs[i].rd_req, vecs[i].wr_ready, vecs[i].rd_ready, wr_ack, rd_ack);
        end

`ifndef ARB_TIMEOUT_EN
        // Write only: ack cycle 1, start cycle 2, done cycle 20, idle cycle 21
        wr_req = 1'b1; wr_req_addr = AW'(32'h100); wr_req_len = LW'(15);
        tick();
        check("wo_ack_c1", 128'({wr_ack, wr_start, grant_wr}), 128'(3'b101));
        wr_req = 1'b0;
        tick();
        check("wo_start_c2", 128'({wr_ack, wr_start, wr_addr, wr_len}), 128'({1'b0, 1'b1, AW'(32'h100), LW'(15)}));
        for (int c = 3; c <= 20; c++) tick();
        check("wo_busy_c20", 128'({busy, wr_start}), 128'(2'b10));
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        check("wo_idle_c21", 128'({busy, grant_wr, wr_addr, wr_len}), 128'({2'b00, AW'(32'h100), LW'(15)}));
        $display("write-only burst complete");
`endif

        // Master not ready
        rd_req = 1'b1; rd_ready = 1'b0; rd_req_addr = AW'(32'h3000); rd_req_len = LW'(7);
        acc = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            acc = acc | rd_ack | rd_start | busy;
        end
        check("notready_idle", 128'(acc), 128'd0);
        rd_ready = 1'b1;
        tick();
        check("notready_ack", 128'({rd_ack, rd_addr, rd_len}), 128'({1'b1, AW'(32'h3000), LW'(7)}));
        rd_req = 1'b0;
        tick();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        $display("read held off by master busy then granted");

        // Stray read done during a write burst
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        tick();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        check("stray_done_wr_busy", 128'({busy, grant_wr}), 128'(2'b11));
        tick();
        check("stray_done_still", 128'({busy, grant_wr}), 128'(2'b11));
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        check("stray_done_release", 128'(busy), 128'd0);
        $display("stray done ignored");

        // Reset in the middle of a read burst
        rd_req = 1'b1; rd_req_addr = AW'(32'h555); rd_req_len = LW'(3);
        tick();
        rd_req = 1'b0;
        tick();
        tick();
        check("midrst_rd_busy", 128'({busy, grant_wr}), 128'(2'b10));
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", dut_vec(), 128'd0);
        wr_req = 1'b1; rd_req = 1'b1; wr_req_addr = AW'(32'h77); rd_req_addr = AW'(32'h88);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("midrst_wr_wins", 128'({wr_ack, rd_ack, wr_addr}), 128'({2'b10, AW'(32'h77)}));
        wr_req = 1'b0; rd_req = 1'b0;
        tick();
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        $display("mid-burst reset recovered");

        // Missing done
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
`ifdef ARB_TIMEOUT_EN
        for (int c = 2; c <= TO + 1; c++) tick();
        check("to_last_busy", 128'({busy, timeout_err}), 128'(2'b10));
        tick();
        check("to_pulse", 128'({busy, timeout_err}), 128'(2'b01));
        tick();
        check("to_pulse_end", 128'(timeout_err), 128'd0);
`else
        for (int c = 2; c <= 100; c++) tick();
        check("nodone_c100", 128'({busy, grant_wr}), 128'(2'b11));
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
`endif
        $display("missing-done case complete");

        // Randomized traffic against the model
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            wr_req = ($urandom_range(0, 2) != 0);
            rd_req = ($urandom_range(0, 2) != 0);
            wr_ready = ($urandom_range(0, 3) != 0);
            rd_ready = ($urandom_range(0, 3) != 0);
            wr_done = ($urandom_range(0, 3) == 0);
            rd_done = ($urandom_range(0, 3) == 0);
            wr_req_addr = AW'($urandom); rd_req_addr = AW'($urandom);
            wr_req_len = LW'($urandom); rd_req_len = LW'($urandom);
            @(posedge clk);
            model_step();
            #1;
            check($sformatf("rand%0d", c), dut_vec(), model_vec());
`ifdef ARB_TIMEOUT_EN
            check($sformatf("rand%0d_to", c), 128'(timeout_err), 128'(m_to));
`endif
        end
        $display("random phase: 600 cycles");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
